// File: rtl/wb_stage.sv
// Write-back stage: selects ALU / PC+4 / extended load data and issues one registered register-file write per instruction.
// Latency: rf_we one cycle after accept (non-load) or after the dmem_rvalid edge (load); in_ready low while waiting for load data.
// Optional feature macro: WB_RETIRE_CNT_EN enables the retire_count write counter.
module wb_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_we,
    input  logic [AW-1:0]   in_rd,
    input  logic [1:0]      in_wbsel,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu,
    input  logic [2:0]      in_funct3,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            rf_we,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            pend_valid,
    output logic [AW-1:0]   pend_rd,
    output logic [31:0]     retire_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]      state;
    logic            lat_we;
    logic [AW-1:0]   lat_rd;
    logic [2:0]      lat_f3;
    logic [1:0]      lat_a;
    logic            accept;
    logic            wr_ok;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    // in_ready is forced low while reset is asserted
    assign in_ready   = rst_n && (state != S_WAIT);
    assign accept     = in_valid && in_ready;
    assign wr_ok      = lat_we && (lat_rd != '0);
    assign pend_valid = (state != S_IDLE) && wr_ok;
    assign pend_rd    = pend_valid ? lat_rd : '0;

    always_comb begin
        ld_byte = dmem_rdata[{lat_a, 3'b000} +: 8];
        ld_half = dmem_rdata[{lat_a[1], 4'b0000} +: 16];
        case (lat_f3)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lat_we   <= 1'b0;
            lat_rd   <= '0;
            lat_f3   <= '0;
            lat_a    <= '0;
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            rf_we <= 1'b0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        state    <= S_WRITE;
                        rf_we    <= wr_ok;
                        rf_wdata <= ld_data;
                    end
                end
                S_IDLE, S_WRITE: begin
                    rf_we <= 1'b0;
                    state <= S_IDLE;
                    if (accept) begin
                        lat_we <= in_we;
                        lat_rd <= in_rd;
                        lat_f3 <= in_funct3;
                        lat_a  <= in_alu[1:0];
                        rf_rd  <= in_rd;
                        if (in_wbsel == 2'b00) begin
                            state <= S_WAIT;
                        end else begin
                            state    <= S_WRITE;
                            rf_we    <= in_we && (in_rd != '0);
                            rf_wdata <= (in_wbsel == 2'b01) ? in_alu : in_pc + XLEN'(4);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    rf_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_q <= '0;
        else if (rf_we)
            retire_q <= retire_q + 32'd1;
    end
    assign retire_count = retire_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage: the writer side of the CPU's 32x32 register file write port (write_enable/rd/data).
- Accepts one retiring instruction per handshake from the MEM stage.
- Selects the write-back source (load data, ALU result or PC+4).
- For loads, waits for the data-memory response and sign/zero-extends and aligns it.
- Issues a single-cycle registered register-file write.
- Exports pending-write info so decode can detect RAW hazards.

Parameters:
XLEN, 32, data/PC width
AW, 5, register address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of any in-flight instruction
in_valid  in  1  MEM stage offers an instruction
in_ready  out  1  stage can accept this cycle
in_we  in  1  instruction writes rd
in_rd  in  AW  destination register
in_wbsel  in  2  00 = load data, 01 = ALU, 10/11 = PC+4
in_pc  in  XLEN  instruction PC (not +4)
in_alu  in  XLEN  ALU result; for loads, the byte address
in_funct3  in  3  load type
dmem_rvalid  in  1  load data valid
dmem_rdata  in  XLEN  raw aligned word from data memory
rf_we  out  1  register-file write enable
rf_rd  out  AW  register-file write address
rf_wdata  out  XLEN  register-file write data
pend_valid  out  1  a write to pend_rd is outstanding
pend_rd  out  AW  outstanding destination
retire_count  out  32  completed-write counter (optional feature)

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0, except in_ready = 1 once rst_n is high.
- States: IDLE, WAIT_LOAD, WRITE.
- in_ready = 1 in IDLE and WRITE; 0 in WAIT_LOAD.
- Accept: in_valid && in_ready at a rising edge.
  - wbsel = 00 -> WAIT_LOAD. Latch rd, we, funct3, and address bits in_alu[1:0].
  - Otherwise -> WRITE, with rf_wdata = in_alu (01) or in_pc + 4 (10/11, mod 2^32).
  - No accept -> IDLE.
- WAIT_LOAD: at the edge where dmem_rvalid = 1, capture the extended data -> WRITE. Otherwise hold.
- WRITE lasts exactly one cycle. rf_we = latched we && (rd != 0). rf_rd and rf_wdata hold valid values.
  - Back-to-back accepts give one rf_we pulse per cycle.
- rf_we, rf_rd and rf_wdata are registered outputs.
  - Non-load latency: accepted at edge N -> rf_we high during the cycle after edge N.
  - Load latency: rvalid sampled at edge M -> rf_we high during the cycle after edge M.
- Load extension (byte offset a = addr[1:0]):
  - 000 LB: sign-extend byte a.
  - 100 LBU: zero-extend byte a.
  - 001 LH: sign-extend halfword addr[1]; addr[0] ignored.
  - 101 LHU: zero-extend halfword addr[1]; addr[0] ignored.
  - 010 and all other codes: full word; addr ignored.
- Load with in_we = 0: still waits for dmem_rvalid, then WRITE with rf_we = 0.
- dmem_rvalid outside WAIT_LOAD is ignored.
- pend_valid = 1 when the state is WAIT_LOAD or WRITE and latched we && rd != 0. pend_rd = latched rd; 0 when not pending.
- flush: at the next edge, state -> IDLE, rf_we = 0, pend_valid = 0.
  - flush has priority over an accept in the same cycle (the offered instruction is dropped).
  - flush has priority over dmem_rvalid in the same cycle.
  - A late rvalid after a flush is ignored.
- Reset mid-load: immediate IDLE; no write issued.

Optional Feature:
WB_RETIRE_CNT_EN:
- Defined: retire_count increments by 1 on each cycle with rf_we = 1; wraps 0xFFFFFFFF -> 0; reset value 0; not cleared by flush.
- Undefined: retire_count is tied to 0 and no counter logic is built.

Test Plan:
- ALU op: accept wbsel = 01, rd = 5, alu = 0x1234 -> next cycle rf_we = 1, rf_rd = 5, rf_wdata = 0x1234, then rf_we = 0.
- JAL link: wbsel = 10, pc = 0x100, rd = 1 -> rf_wdata = 0x104. Separately, rd = 0 -> rf_we stays 0.
- Loads: rdata = 0x80FF7F01.
  - LB, a = 3 -> 0xFFFFFF80.
  - LBU, a = 1 -> 0x0000007F.
  - LH, a = 2 -> 0xFFFF80FF.
  - LHU, a = 0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- Load stall: accept a load with rd = 7; hold dmem_rvalid low for 3 cycles. Required:
  - in_ready = 0 throughout.
  - pend_valid = 1 with pend_rd = 7.
  - After rvalid, exactly one write.
- Flush in WAIT_LOAD with a simultaneous rvalid -> no rf_we, state IDLE, and a later rvalid is ignored. Separately, async reset asserted mid-load clears all outputs immediately.
- Back-to-back: 4 ALU ops with in_valid held high -> 4 consecutive rf_we pulses. With WB_RETIRE_CNT_EN defined, retire_count = 4.
